// File: rtl/instr_entry.sv
// Board-input front end: debounces the two DE2 keys, captures the slide-switch
// word on each load press into a small FWFT FIFO drained by the core via valid/ready.
module instr_entry #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 4,
    parameter int DB_CYCLES = 50000
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic [1:0]               KEYn,
    input  logic [DATA_W-1:0]        SW,
    output logic [DATA_W-1:0]        instr_out,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [1:0]        sync1_q, sync2_q;
    logic [1:0]        db_q, db_d;
    logic [CNT_W-1:0]  dbcnt_q [2];
    logic [CNT_W-1:0]  dbcnt_d [2];
    logic [1:0]        press_s;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              flush_s, load_s, pop_s, push_s;

    // Debounce: a level is accepted only after DB_CYCLES consecutive differing samples
    always_comb begin
        db_d    = db_q;
        press_s = 2'b00;
        for (int k = 0; k < 2; k++) begin
            dbcnt_d[k] = '0;
            if (sync2_q[k] == db_q[k]) begin
                dbcnt_d[k] = '0;
            end else if (dbcnt_q[k] == DB_LAST) begin
                db_d[k]    = sync2_q[k];
                dbcnt_d[k] = '0;
                press_s[k] = ~sync2_q[k];
            end else begin
                dbcnt_d[k] = dbcnt_q[k] + CNT_W'(1);
            end
        end
    end

    // FIFO control; flush overrides any same-cycle load or pop
    always_comb begin
        flush_s  = press_s[1];
        load_s   = press_s[0] & ~flush_s;
        pop_s    = instr_valid & instr_ready & ~flush_s;
        push_s   = load_s & (~full | pop_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush_s) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            else        wr_ptr_d = wr_ptr_q;
            if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            else        rd_ptr_d = rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
            if (load_s & full & ~pop_s) ovf_d = 1'b1;
            else                        ovf_d = ovf_q;
        end
    end

    // Key synchronizer and debounce state; released (1) out of reset
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            db_q    <= 2'b11;
            for (int k = 0; k < 2; k++) dbcnt_q[k] <= '0;
        end else begin
            sync1_q <= KEYn;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            for (int k = 0; k < 2; k++) dbcnt_q[k] <= dbcnt_d[k];
        end
    end

    // FIFO storage, pointers, occupancy and sticky overflow
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_s) mem_q[wr_ptr_q] <= SW;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign instr_out   = mem_q[rd_ptr_q];
    assign instr_valid = (count_q != '0);
    assign full        = (count_q == DEPTH_C);
    assign count       = count_q;
    assign overflow    = ovf_q;

endmodule

// File: doc/instr_entry.md
Name: instr_entry

Overview:
Input-side front end of the DE2 board wrapper: captures 16-bit instruction words from the slide switches on debounced push-button presses and buffers them in a small FIFO. The processor core drains the FIFO through a valid/ready handshake. This is the reverse direction of the display path (core -> HEX/LEDR); here board inputs (SW/KEY) feed the core. Status outputs drive LEDG/LEDR.

Parameters:
DATA_W, 16, instruction word width (matches processor bus width)
DEPTH, 4, FIFO entries; power of two, minimum 2
DB_CYCLES, 50000, consecutive stable cycles required to accept a key level (1 ms at 50 MHz)

Ports:
Clock  input  1  system clock
Resetn  input  1  asynchronous, active-low reset
KEYn  input  2  raw DE2 push buttons, active-low; [0]=load, [1]=flush
SW  input  DATA_W  instruction word from slide switches
instr_out  output  DATA_W  FIFO head word
instr_valid  output  1  high when FIFO non-empty
instr_ready  input  1  core accepts head word this cycle
count  output  log2(DEPTH)+1  number of stored words
full  output  1  count == DEPTH
overflow  output  1  sticky: a load was dropped because FIFO was full

Behaviour:
- Reset (async, Resetn=0): FIFO pointers and count=0, instr_valid=0, full=0, overflow=0, instr_out=0. Synchronizer and debounced levels =1 (released). Debounce counters =0. No press is ever generated by reset release.
- Synchronizer: each KEYn bit passes through 2 flops before use.
- Debounce, per key: counter clears when the synced level equals the debounced level. Otherwise it increments. When it reaches DB_CYCLES-1 while still differing, the debounced level takes the synced level and the counter clears. Any bounce before that clears the counter.
- Press pulse: exactly one cycle, on the debounced 1->0 transition. Release produces no pulse. Holding a key produces exactly one press.
- Latency: a clean raw press yields a press pulse DB_CYCLES+2 cycles after the raw fall (±1). The pushed word is visible on instr_out/instr_valid the cycle after the pulse.
- Load pulse: SW is sampled on the pulse cycle and written at the tail.
- If full and no pop in the same cycle, the word is dropped and overflow is set.
- If full with a simultaneous pop, the write is accepted and count is unchanged.
- Pop: instr_valid & instr_ready advances the head. instr_ready is ignored when empty.
- Simultaneous push and pop when non-empty: count unchanged. Order is preserved.
- Flush pulse: pointers and count go to 0 and overflow clears. Flush dominates a same-cycle load and pop (neither takes effect).
- Both keys pressed: handled per the flush rule above.
- instr_out is first-word-fall-through from a registered array. It is stable while instr_valid & ~instr_ready. It is don't-care but deterministic (last head) when empty.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH.
- full and instr_valid are derived from count with no extra latency.
- Mid-operation Resetn assertion clears everything immediately, including a partially counted debounce.

Test Plan:
- Params DB_CYCLES=4, DEPTH=4. Reset, then raw KEYn[0] low for 20 cycles with SW=16'hA5C3 -> one press pulse ~6 cycles after the fall; then instr_valid=1, instr_out=A5C3, count=1. Holding the key gives no second push.
- Bounce: KEYn[0] toggles every 2 cycles for 12 cycles, then stays high -> no push, count=0.
- Fill: 5 clean presses with SW=1,2,3,4,5 and instr_ready=0 -> count=4, full=1, overflow=1. Set instr_ready=1 -> outputs 1,2,3,4 in order, then instr_valid=0.
- Full with simultaneous pop: full FIFO, instr_ready=1 held, press load with SW=16'h0077 -> count stays 4, no overflow, 0077 drains last.
- Flush: 3 words stored and overflow=1. Press KEYn[1] while a load pulse lands in the same cycle -> count=0, instr_valid=0, overflow=0, the load is ignored.
- Reset mid-debounce: Resetn low for 1 cycle, 2 cycles into a press -> all outputs 0. The key still held low must then complete the full DB_CYCLES before pushing once.
